// File: rtl/load_store_unit.sv
// Load/store unit: turns MEM-stage byte/half/word requests into word-wide
// data-memory reads, read-modify-write sequences and extended load results.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              MemRead,
    output logic [ADDR_W-1:0] ReadAddress,
    input  logic [31:0]       ReadData,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] WriteAddress,
    output logic [31:0]       WriteData
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        MERGE,
        WRITE,
        RESP
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t            state;
    logic              is_load_q;
    logic              unsigned_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [31:0]       write_word;

    logic              req_err;
    logic              req_accept;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [31:0]       load_ext;
    logic [31:0]       merged;

    assign req_accept = req_valid && (req_load || req_store);
    assign req_err    = (req_size == 2'b11)
                     || (req_size == SIZE_HALF && req_addr[0])
                     || (req_size == SIZE_WORD && req_addr[1:0] != 2'b00);

    // Memory-side and handshake outputs depend only on registered state.
    assign busy         = (state != IDLE);
    assign resp_valid   = (state == RESP);
    assign MemRead      = (state == READ);
    assign MemWrite     = (state == WRITE);
    assign ReadAddress  = {addr_q[ADDR_W-1:2], 2'b00};
    assign WriteAddress = {addr_q[ADDR_W-1:2], 2'b00};
    assign WriteData    = write_word;

    assign byte_lane = ReadData[{addr_q[1:0], 3'b000} +: 8];
    assign half_lane = ReadData[{addr_q[1], 4'b0000} +: 16];

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        load_ext = ReadData;
        merged   = ReadData;
        case (size_q)
            SIZE_BYTE: begin
                load_ext = {{24{~unsigned_q & byte_lane[7]}}, byte_lane};
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            SIZE_HALF: begin
                load_ext = {{16{~unsigned_q & half_lane[15]}}, half_lane};
                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
            end
            default: ;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            is_load_q  <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_word <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_accept) begin
                        is_load_q  <= req_load;
                        unsigned_q <= req_unsigned;
                        size_q     <= req_size;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata[15:0];
                        resp_err   <= req_err;
                        if (req_err) begin
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else if (req_load || req_size != SIZE_WORD) begin
                            state <= READ;
                        end else begin
                            write_word <= req_wdata;
                            state      <= WRITE;
                        end
                    end
                end
                READ:    state <= is_load_q ? CAPTURE : MERGE;
                CAPTURE: begin
                    resp_rdata <= load_ext;
                    state      <= RESP;
                end
                MERGE: begin
                    write_word <= merged;
                    state      <= WRITE;
                end
                WRITE: begin
                    resp_rdata <= '0;
                    state      <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a word-addressed data memory plus
// a behavioural model of byte/half/word load/store semantics.
module tb_load_store_unit;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_load;
    logic              req_store;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              busy;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              MemRead;
    logic [ADDR_W-1:0] ReadAddress;
    logic [31:0]       ReadData;
    logic              MemWrite;
    logic [ADDR_W-1:0] WriteAddress;
    logic [31:0]       WriteData;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;
    logic [31:0] last_waddr;
    int read_cnt = 0, write_cnt = 0, overlap_cnt = 0, resp_cnt = 0;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .MemRead(MemRead),
        .ReadAddress(ReadAddress), .ReadData(ReadData), .MemWrite(MemWrite),
        .WriteAddress(WriteAddress), .WriteData(WriteData)
    );

    // Read-priority word memory with registered read data; unaffected by DUT reset.
    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (MemWrite) mem[WriteAddress[7:2]] <= WriteData;
        if (MemRead) ReadData <= mem[ReadAddress[7:2]];
        if (MemRead) read_cnt <= read_cnt + 1;
        if (MemWrite) begin
            write_cnt  <= write_cnt + 1;
            last_waddr <= WriteAddress;
        end
        if (MemRead && MemWrite) overlap_cnt <= overlap_cnt + 1;
    end

    always @(negedge clk) if (resp_valid) resp_cnt <= resp_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit model_err(logic [1:0] sz, logic [31:0] addr);
        return (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0);
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] word, logic [1:0] sz, bit uns, logic [31:0] addr);
        longint v;
        int shift = 8 * int'(addr % 4);
        if (sz == 2'd2) return word;
        if (sz == 2'd0) begin
            v = (longint'(word) >> shift) % 256;
            if (!uns && v >= 128) v -= 256;
        end else begin
            v = (longint'(word) >> shift) % 65536;
            if (!uns && v >= 32768) v -= 65536;
        end
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_store(logic [31:0] word, logic [1:0] sz, logic [31:0] addr, logic [31:0] wd);
        longint width, mask, shift, res;
        if (sz == 2'd2) return wd;
        width = (sz == 2'd0) ? 8 : 16;
        shift = 8 * longint'(addr % 4);
        mask  = ((longint'(1) << width) - 1) << shift;
        res   = (longint'(word) & ~mask) | ((longint'(wd) & ((longint'(1) << width) - 1)) << shift);
        return res[31:0];
    endfunction

    function automatic int model_latency(bit ld, logic [1:0] sz, logic [31:0] addr);
        if (model_err(sz, addr)) return 1;
        if (ld) return 3;
        return (sz == 2'd2) ? 2 : 4;
    endfunction

    // ---------------- drivers ----------------
    task automatic set_req(input bit v, input bit ld, input bit st, input logic [1:0] sz,
                           input bit uns, input logic [31:0] addr, input logic [31:0] wd);
        req_valid = v; req_load = ld; req_store = st; req_size = sz;
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx[5:0]; pre_data = d;
        ref_mem[idx] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issues one request from IDLE and returns response data and edge latency.
    task automatic do_req(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int nrd, output int nwr);
        int r0, w0;
        @(negedge clk);
        r0 = read_cnt; w0 = write_cnt;
        set_req(1'b1, ld, st, sz, uns, addr, wd);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata; er = resp_err;
        nrd = read_cnt - r0; nwr = write_cnt - w0;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if ({busy, resp_valid, resp_err, MemRead, MemWrite} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got busy/rv/err/rd/wr=%b expected 00000",
                     {busy, resp_valid, resp_err, MemRead, MemWrite});
        end
        checks++;
        if ({resp_rdata, ReadAddress, WriteAddress, WriteData} !== 128'h0) begin
            failures++;
            $display("FAIL reset_data: rdata=%h raddr=%h waddr=%h wdata=%h expected all 0",
                     resp_rdata, ReadAddress, WriteAddress, WriteData);
        end
    endtask

    task automatic test_word_store_load();
        logic [31:0] rd; logic er; int lat, nrd, nwr;
        do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, nrd, nwr);
        ref_mem[4] = 32'hDEADBEEF;
        checks++;
        if (lat !== 2 || nwr !== 1 || nrd !== 0 || er !== 1'b0) begin
            failures++;
            $display("FAIL sw_timing: lat=%0d writes=%0d reads=%0d err=%b expected 2/1/0/0", lat, nwr, nrd, er);
        end
        checks++;
        if (last_waddr !== 32'h10 || mem[4] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL sw_commit: waddr=%h mem=%h expected 00000010/deadbeef", last_waddr, mem[4]);
        end
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, nrd, nwr);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 3) begin
            failures++;
            $display("FAIL lw_after_sw: rdata=%h err=%b lat=%0d expected deadbeef/0/3", rd, er, lat);
        end
    endtask

    task automatic test_byte_rmw();
        logic [31:0] rd; logic er; int lat, nrd, nwr, ov0;
        preload(8, 32'h11223344);
        ov0 = overlap_cnt;
        do_req(1'b0, 1'b1, 2'd0, 1'b0, 32'h22, 32'h123456AA, rd, er, lat, nrd, nwr);
        ref_mem[8] = 32'h11AA3344;
        checks++;
        if (mem[8] !== 32'h11AA3344) begin
            failures++;
            $display("FAIL sb_rmw_word: mem=%h expected 11aa3344", mem[8]);
        end
        checks++;
        if (lat !== 4 || nrd !== 1 || nwr !== 1 || overlap_cnt !== ov0 || rd !== 32'h0) begin
            failures++;
            $display("FAIL sb_rmw_seq: lat=%0d reads=%0d writes=%0d overlap=%0d rdata=%h expected 4/1/1/%0d/0",
                     lat, nrd, nwr, overlap_cnt, rd, ov0);
        end
    endtask

    task automatic test_load_ext();
        logic [1:0]  sz_t  [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        bit          uns_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] adr_t [4] = '{32'h06, 32'h07, 32'h04, 32'h06};
        logic [31:0] exp_t [4] = '{32'hFFFFFFFF, 32'h00000080, 32'h00007F01, 32'h000080FF};
        logic [31:0] rd; logic er; int lat, nrd, nwr;
        preload(1, 32'h80FF7F01);
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 1'b0, sz_t[i], uns_t[i], adr_t[i], 32'h0, rd, er, lat, nrd, nwr);
            checks++;
            if (rd !== exp_t[i] || er !== 1'b0 || lat !== 3) begin
                failures++;
                $display("FAIL load_ext[%0d]: rdata=%h err=%b lat=%0d expected %h/0/3",
                         i, rd, er, lat, exp_t[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        bit          ld_t  [3] = '{1'b1, 1'b0, 1'b1};
        logic [1:0]  sz_t  [3] = '{2'd2, 2'd1, 2'd3};
        logic [31:0] adr_t [3] = '{32'h05, 32'h03, 32'h08};
        logic [31:0] rd; logic er; int lat, nrd, nwr;
        for (int i = 0; i < 3; i++) begin
            do_req(ld_t[i], !ld_t[i], sz_t[i], 1'b0, adr_t[i], 32'hFFFF_FFFF, rd, er, lat, nrd, nwr);
            checks++;
            if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || nrd !== 0 || nwr !== 0) begin
                failures++;
                $display("FAIL misaligned[%0d]: err=%b rdata=%h lat=%0d reads=%0d writes=%0d expected 1/0/1/0/0",
                         i, er, rd, lat, nrd, nwr);
            end
        end
    endtask

    task automatic test_ignored();
        int r0;
        bit saw_busy = 1'b0;
        @(negedge clk);
        r0 = read_cnt;
        set_req(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        repeat (3) begin
            @(posedge clk); #1;
            if (busy) saw_busy = 1'b1;
        end
        set_req(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (saw_busy !== 1'b0 || read_cnt !== r0) begin
            failures++;
            $display("FAIL no_op_ignored: busy_seen=%b reads=%0d expected 0/0", saw_busy, read_cnt - r0);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wd, exp_rd; logic er; int lat, nrd, nwr, kind, bad;
        logic [1:0] sz; bit ld, st, uns, e;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 3);
            ld = (kind != 2); st = (kind >= 2);
            sz = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 255));
            wd = $urandom;
            e = model_err(sz, addr);
            exp_rd = (e || !ld) ? 32'h0 : model_load(ref_mem[addr[7:2]], sz, uns, addr);
            do_req(ld, st, sz, uns, addr, wd, rd, er, lat, nrd, nwr);
            if (!e && !ld) ref_mem[addr[7:2]] = model_store(ref_mem[addr[7:2]], sz, addr, wd);
            checks++;
            if (rd !== exp_rd || er !== e || lat !== model_latency(ld, sz, addr)
                || nrd !== ((!e && (ld || sz != 2'd2)) ? 1 : 0) || nwr !== ((!e && !ld) ? 1 : 0)) begin
                failures++;
                $display("FAIL random[%0d] ld=%b sz=%0d uns=%b addr=%h: rdata=%h err=%b lat=%0d rd/wr=%0d/%0d expected %h/%b/%0d",
                         i, ld, sz, uns, addr, rd, er, lat, nrd, nwr, exp_rd, e, model_latency(ld, sz, addr));
            end
        end
        bad = 0;
        for (int w = 0; w < 64; w++) if (mem[w] !== ref_mem[w]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL random_mem_image: %0d words differ, expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 8;
        bit          ld_a  [N];
        logic [1:0]  sz_a  [N];
        bit          uns_a [N];
        logic [31:0] adr_a [N];
        logic [31:0] wd_a  [N];
        logic [31:0] exp_rd; bit e;
        int lat, r0, low_cnt;
        for (int i = 0; i < N; i++) begin
            ld_a[i] = (i % 2 == 0);
            sz_a[i] = 2'($urandom_range(0, 2));
            uns_a[i] = 1'($urandom_range(0, 1));
            adr_a[i] = 32'($urandom_range(0, 63)) << sz_a[i];
            wd_a[i] = $urandom;
        end
        adr_a[3] = 32'h41; sz_a[3] = 2'd2;
        @(negedge clk);
        r0 = resp_cnt; low_cnt = 0;
        set_req(1'b1, ld_a[0], !ld_a[0], sz_a[0], uns_a[0], adr_a[0], wd_a[0]);
        for (int i = 0; i < N; i++) begin
            if (!busy) low_cnt++;
            e = model_err(sz_a[i], adr_a[i]);
            exp_rd = (e || !ld_a[i]) ? 32'h0 : model_load(ref_mem[adr_a[i][7:2]], sz_a[i], uns_a[i], adr_a[i]);
            @(posedge clk); #1;
            if (i + 1 < N)
                set_req(1'b1, ld_a[i+1], !ld_a[i+1], sz_a[i+1], uns_a[i+1], adr_a[i+1], wd_a[i+1]);
            else
                set_req(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
            lat = 1;
            if (!busy) low_cnt++;
            while (!resp_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
                if (!busy) low_cnt++;
            end
            if (!e && !ld_a[i])
                ref_mem[adr_a[i][7:2]] = model_store(ref_mem[adr_a[i][7:2]], sz_a[i], adr_a[i], wd_a[i]);
            checks++;
            if (resp_rdata !== exp_rd || resp_err !== e || lat !== model_latency(ld_a[i], sz_a[i], adr_a[i])) begin
                failures++;
                $display("FAIL b2b[%0d]: rdata=%h err=%b lat=%0d expected %h/%b/%0d", i, resp_rdata, resp_err,
                         lat, exp_rd, e, model_latency(ld_a[i], sz_a[i], adr_a[i]));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (resp_cnt - r0 !== N || low_cnt !== N || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_handshake: responses=%0d busy_low_cycles=%0d busy=%b expected %0d/%0d/0",
                     resp_cnt - r0, low_cnt, busy, N, N);
        end
    endtask

    task automatic test_reset_in_merge();
        int rc0, wc0;
        preload(8, 32'h11223344);
        @(negedge clk);
        set_req(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA);
        @(posedge clk); #1;                       // READ
        set_req(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;                       // MERGE
        rc0 = resp_cnt; wc0 = write_cnt;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({busy, resp_valid, resp_err, MemRead, MemWrite} !== 5'b0
            || {resp_rdata, ReadAddress, WriteAddress, WriteData} !== 128'h0) begin
            failures++;
            $display("FAIL reset_merge_outputs: ctrl=%b rdata=%h raddr=%h waddr=%h wdata=%h expected all 0",
                     {busy, resp_valid, resp_err, MemRead, MemWrite}, resp_rdata, ReadAddress, WriteAddress, WriteData);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (mem[8] !== ref_mem[8] || resp_cnt !== rc0 || write_cnt !== wc0) begin
            failures++;
            $display("FAIL reset_merge_effects: mem=%h resp=%0d writes=%0d expected %h/0/0",
                     mem[8], resp_cnt - rc0, write_cnt - wc0, ref_mem[8]);
        end
    endtask

    task automatic test_reset_in_write();
        int rc0;
        @(negedge clk);
        rc0 = resp_cnt;
        set_req(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D);
        @(posedge clk); #1;                       // WRITE
        set_req(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ref_mem[12] = 32'hCAFEF00D;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (mem[12] !== 32'hCAFEF00D || resp_cnt !== rc0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_write_commit: mem=%h resp=%0d busy=%b expected cafef00d/0/0",
                     mem[12], resp_cnt - rc0, busy);
        end
    endtask

    initial begin
        pre_we = 1'b0; pre_idx = '0; pre_data = '0;
        set_req(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        for (int w = 0; w < 64; w++) preload(w, $urandom);
        test_reset();
        test_word_store_load();
        test_byte_rmw();
        test_load_ext();
        test_misaligned();
        test_ignored();
        test_random();
        test_back_to_back();
        test_reset_in_merge();
        test_reset_in_write();
        checks++;
        if (overlap_cnt !== 0) begin
            failures++;
            $display("FAIL read_write_overlap: cycles=%0d expected 0", overlap_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
